// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Included by the arbiter top and its response register.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W  = 10;
    localparam int unsigned DMEM_DATA_W  = 32;
    localparam int unsigned DMEM_BMASK_W = DMEM_DATA_W / 8;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0]  addr;
        logic [DMEM_DATA_W-1:0]  wdata;
        logic [DMEM_BMASK_W-1:0] bmask;
        logic                    wren;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_IDLE = '0;

    // Bundle one master's request fields into a memory request.
    function automatic mem_req_t make_req(
        input logic [DMEM_ADDR_W-1:0]  addr,
        input logic [DMEM_DATA_W-1:0]  wdata,
        input logic [DMEM_BMASK_W-1:0] bmask,
        input logic                    wren
    );
        mem_req_t r;
        r.addr  = addr;
        r.wdata = wdata;
        r.bmask = bmask;
        r.wren  = wren;
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rsp.sv
// Per-master read-response register: captures memory read data one cycle
// after a granted read and strobes rvalid for exactly that cycle.
module dmem_arbiter_rsp
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rd_fire,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_rvalid,
    output logic [DATA_W-1:0] o_rdata
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
        end else begin
            o_rvalid <= i_rd_fire;
            if (i_rd_fire) begin
                o_rdata <= i_mem_rdata;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: fixed priority to the
// LSU (M0), starvation-bounded access and burst locking for the loader (M1).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DMEM_ADDR_W,
    parameter int unsigned DATA_W     = DMEM_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,

    input  logic                i_m0_req,
    input  logic [ADDR_W-1:0]   i_m0_addr,
    input  logic [DATA_W-1:0]   i_m0_wdata,
    input  logic [DATA_W/8-1:0] i_m0_bmask,
    input  logic                i_m0_wren,
    output logic                o_m0_gnt,
    output logic                o_m0_rvalid,
    output logic [DATA_W-1:0]   o_m0_rdata,

    input  logic                i_m1_req,
    input  logic [ADDR_W-1:0]   i_m1_addr,
    input  logic [DATA_W-1:0]   i_m1_wdata,
    input  logic [DATA_W/8-1:0] i_m1_bmask,
    input  logic                i_m1_wren,
    input  logic                i_m1_lock,
    output logic                o_m1_gnt,
    output logic                o_m1_rvalid,
    output logic [DATA_W-1:0]   o_m1_rdata,

    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    output logic                o_mem_wren,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int unsigned BMASK_W = DATA_W / 8;
    localparam int unsigned CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             m0_win;
    logic             m1_win;
    mem_req_t         m0_bus;
    mem_req_t         m1_bus;
    mem_req_t         mem_bus;

    assign m0_bus = make_req(DMEM_ADDR_W'(i_m0_addr), DMEM_DATA_W'(i_m0_wdata),
                             DMEM_BMASK_W'(i_m0_bmask), i_m0_wren);
    assign m1_bus = make_req(DMEM_ADDR_W'(i_m1_addr), DMEM_DATA_W'(i_m1_wdata),
                             DMEM_BMASK_W'(i_m1_bmask), i_m1_wren);

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a locked M1 grant opens a burst that lasts until lock drops.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB: begin
                if (m1_win && i_m1_lock) begin
                    state_nxt = LOCK1;
                end
            end
            LOCK1: begin
                if (!i_m1_lock) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Grant decision and memory-port mux.
    always_comb begin
        m0_win  = 1'b0;
        m1_win  = 1'b0;
        mem_bus = MEM_REQ_IDLE;
        case (state)
            ARB: begin
                if (i_m1_req && (starve_cnt == CNT_MAX)) begin
                    m1_win = 1'b1;
                end else if (i_m0_req) begin
                    m0_win = 1'b1;
                end else if (i_m1_req) begin
                    m1_win = 1'b1;
                end
            end
            LOCK1: begin
                m1_win = i_m1_req;
            end
            default: begin
                m0_win = 1'b0;
                m1_win = 1'b0;
            end
        endcase
        if (m0_win) begin
            mem_bus = m0_bus;
        end else if (m1_win) begin
            mem_bus = m1_bus;
        end
        // A write must never reach the array while reset is held.
        if (i_reset) begin
            mem_bus.wren = 1'b0;
        end
    end

    assign o_m0_gnt    = m0_win;
    assign o_m1_gnt    = m1_win;
    assign o_mem_addr  = ADDR_W'(mem_bus.addr);
    assign o_mem_wdata = DATA_W'(mem_bus.wdata);
    assign o_mem_bmask = BMASK_W'(mem_bus.bmask);
    assign o_mem_wren  = mem_bus.wren;

    // Counts consecutive arbitration cycles in which M1 asked and lost.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            starve_cnt <= '0;
        end else if (!i_m1_req || m1_win) begin
            starve_cnt <= '0;
        end else if ((state == ARB) && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    dmem_arbiter_rsp #(
        .DATA_W (DATA_W)
    ) u_rsp_m0 (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rd_fire   (m0_win && !i_m0_wren),
        .i_mem_rdata (i_mem_rdata),
        .o_rvalid    (o_m0_rvalid),
        .o_rdata     (o_m0_rdata)
    );

    dmem_arbiter_rsp #(
        .DATA_W (DATA_W)
    ) u_rsp_m1 (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rd_fire   (m1_win && !i_m1_wren),
        .i_mem_rdata (i_mem_rdata),
        .o_rvalid    (o_m1_rvalid),
        .o_rdata     (o_m1_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_dmem_arbiter;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned SMAX  = 4;
    localparam int unsigned WORDS = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_wren, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [BW-1:0] m0_bmask;
    logic          m1_req, m1_wren, m1_lock, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [BW-1:0] m1_bmask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [BW-1:0] mem_bmask;
    logic          mem_wren;

    int vectors    = 0;
    int miscompares = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .i_m0_bmask(m0_bmask), .i_m0_wren(m0_wren), .o_m0_gnt(m0_gnt),
        .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .i_m1_bmask(m1_bmask), .i_m1_wren(m1_wren), .i_m1_lock(m1_lock),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
        .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] mask);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < int'(BW); b++)
            if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Memory the DUT actually talks to (combinational read, 0 during writes).
    logic [DW-1:0] mem     [WORDS];
    logic [DW-1:0] ref_mem [WORDS];
    assign mem_rdata = mem_wren ? '0 : mem[mem_addr[AW-1:2]];
    always @(posedge clk)
        if (mem_wren) mem[mem_addr[AW-1:2]] <= merge(mem[mem_addr[AW-1:2]], mem_wdata, mem_bmask);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the port, how long M1 has waited,
    // and what each master's response register must show.
    logic          mdl_locked;
    int            mdl_starve;
    int            mdl_win;
    logic          mdl_rv [2];
    logic [DW-1:0] mdl_rd [2];
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_bmask;
    logic          e_wren;

    always @(negedge clk) begin
        if (rst) begin
            mdl_locked = 1'b0;
            mdl_starve = 0;
            mdl_rv[0] = 1'b0; mdl_rv[1] = 1'b0;
            mdl_rd[0] = '0;   mdl_rd[1] = '0;
        end
        if (mdl_locked)                          mdl_win = m1_req ? 1 : -1;
        else if (m1_req && mdl_starve >= SMAX)   mdl_win = 1;
        else if (m0_req)                         mdl_win = 0;
        else if (m1_req)                         mdl_win = 1;
        else                                     mdl_win = -1;

        e_addr = '0; e_wdata = '0; e_bmask = '0; e_wren = 1'b0;
        if (mdl_win == 0) begin
            e_addr = m0_addr; e_wdata = m0_wdata; e_bmask = m0_bmask; e_wren = m0_wren;
        end else if (mdl_win == 1) begin
            e_addr = m1_addr; e_wdata = m1_wdata; e_bmask = m1_bmask; e_wren = m1_wren;
        end
        if (rst) e_wren = 1'b0;

        chk("m0_gnt",    64'(m0_gnt),    64'(mdl_win == 0));
        chk("m1_gnt",    64'(m1_gnt),    64'(mdl_win == 1));
        chk("m0_rvalid", 64'(m0_rvalid), 64'(mdl_rv[0]));
        chk("m1_rvalid", 64'(m1_rvalid), 64'(mdl_rv[1]));
        chk("m0_rdata",  64'(m0_rdata),  64'(mdl_rd[0]));
        chk("m1_rdata",  64'(m1_rdata),  64'(mdl_rd[1]));
        chk("mem_addr",  64'(mem_addr),  64'(e_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        chk("mem_bmask", 64'(mem_bmask), 64'(e_bmask));
        chk("mem_wren",  64'(mem_wren),  64'(e_wren));

        if (!rst) begin
            mdl_rv[0] = (mdl_win == 0) && !m0_wren;
            mdl_rv[1] = (mdl_win == 1) && !m1_wren;
            if (mdl_rv[0]) mdl_rd[0] = ref_mem[m0_addr[AW-1:2]];
            if (mdl_rv[1]) mdl_rd[1] = ref_mem[m1_addr[AW-1:2]];
            if (e_wren) ref_mem[e_addr[AW-1:2]] = merge(ref_mem[e_addr[AW-1:2]], e_wdata, e_bmask);
            mdl_locked = mdl_locked ? m1_lock : ((mdl_win == 1) && m1_lock);
            if (!m1_req || mdl_win == 1) mdl_starve = 0;
            else if (mdl_starve < SMAX)  mdl_starve++;
        end
    end

    // Grants seen in the cycle just finished, for the masters' hold-until-grant rule.
    logic g0_seen, g1_seen;
    always @(negedge clk) begin
        g0_seen <= m0_gnt;
        g1_seen <= m1_gnt;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_all();
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_bmask = '0; m0_wren = 1'b0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_bmask = '0; m1_wren = 1'b0;
        m1_lock = 1'b0;
    endtask

    logic [9:0] m1_pat;

    initial begin
        for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h11223344;
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = mem[i];
        rst = 1'b1;
        idle_all();
        tick();
        #1;
        chk("rst_wren",      64'(mem_wren),  64'h0);
        chk("rst_m0_rvalid", 64'(m0_rvalid), 64'h0);
        chk("rst_m1_rvalid", 64'(m1_rvalid), 64'h0);
        chk("rst_m0_rdata",  64'(m0_rdata),  64'h0);
        tick();
        rst = 1'b0;

        // No requests: port idles.
        repeat (2) begin
            tick(); #1;
            chk("idle_gnt",   64'({m0_gnt, m1_gnt}), 64'h0);
            chk("idle_bmask", 64'(mem_bmask),        64'h0);
            chk("idle_wren",  64'(mem_wren),         64'h0);
        end

        // Lone M0 read of word 4.
        m0_req = 1'b1; m0_addr = 10'h010; m0_bmask = 4'hF; m0_wren = 1'b0;
        #1 chk("t1_gnt", 64'(m0_gnt), 64'h1);
        tick(); idle_all(); #1;
        chk("t1_rvalid",    64'(m0_rvalid), 64'h1);
        chk("t1_rdata",     64'(m0_rdata),  64'hDEADBEEF);
        chk("t1_m1_rvalid", 64'(m1_rvalid), 64'h0);

        // Both masters saturate: M1 gets every fifth slot.
        m1_pat = 10'b1000010000;
        m0_req = 1'b1; m0_addr = 10'h000;
        m1_req = 1'b1; m1_addr = 10'h004;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t2_m1_gnt", 64'(m1_gnt), 64'(m1_pat[k]));
            chk("t2_m0_gnt", 64'(m0_gnt), 64'(!m1_pat[k]));
            tick();
        end

        // M1 burst lock shuts M0 out until lock drops.
        idle_all(); tick();
        m1_req = 1'b1; m1_addr = 10'h008; m1_lock = 1'b1;
        #1 chk("t3_a_m1_gnt", 64'(m1_gnt), 64'h1);
        tick();
        m0_req = 1'b1; m0_addr = 10'h00C;
        repeat (2) begin
            #1;
            chk("t3_m0_gnt", 64'(m0_gnt), 64'h0);
            chk("t3_m1_gnt", 64'(m1_gnt), 64'h1);
            tick();
        end
        m1_req = 1'b0; m1_lock = 1'b0;
        #1 chk("t3_drop_gnt", 64'({m0_gnt, m1_gnt}), 64'h0);
        tick(); #1;
        chk("t3_m0_after", 64'(m0_gnt), 64'h1);
        tick();

        // Partial write then read-back of word 8.
        idle_all();
        m0_req = 1'b1; m0_addr = 10'h020; m0_wdata = 32'hAABBCCDD; m0_bmask = 4'b0011; m0_wren = 1'b1;
        #1 chk("t4_wren", 64'(mem_wren), 64'h1);
        tick();
        m0_wren = 1'b0; m0_bmask = 4'hF; m0_wdata = '0;
        #1 chk("t4_no_wr_rsp", 64'(m0_rvalid), 64'h0);
        tick(); idle_all(); #1;
        chk("t4_rvalid", 64'(m0_rvalid), 64'h1);
        chk("t4_rdata",  64'(m0_rdata),  64'h1122CCDD);

        // Reset lands while M1 owns the port with a read response pending.
        m1_req = 1'b1; m1_addr = 10'h00C; m1_lock = 1'b1;
        tick();
        m1_wren = 1'b1; m1_wdata = 32'h55AA55AA; m1_bmask = 4'hF;
        #1 chk("t5_pre_rvalid", 64'(m1_rvalid), 64'h1);
        rst = 1'b1;
        #1;
        chk("t5_rvalid", 64'(m1_rvalid), 64'h0);
        chk("t5_wren",   64'(mem_wren),  64'h0);
        tick(); tick();
        rst = 1'b0;
        idle_all();
        m0_req = 1'b1; m0_addr = 10'h004;
        m1_req = 1'b1; m1_addr = 10'h008;
        #1;
        chk("t5_m0_first", 64'(m0_gnt), 64'h1);
        chk("t5_m1_wait",  64'(m1_gnt), 64'h0);
        tick();

        // Randomized traffic; masters hold a request until it is granted.
        idle_all();
        tick();
        for (int c = 0; c < 3000; c++) begin
            if (!m0_req || g0_seen) begin
                m0_req   = ($urandom_range(0, 9) < 6);
                m0_addr  = AW'($urandom_range(0, (1 << AW) - 1));
                m0_wdata = $urandom;
                m0_bmask = BW'($urandom);
                m0_wren  = $urandom_range(0, 1) == 1;
            end
            if (!m1_req || g1_seen) begin
                m1_req   = ($urandom_range(0, 9) < 5);
                m1_addr  = AW'($urandom_range(0, (1 << AW) - 1));
                m1_wdata = $urandom;
                m1_bmask = BW'($urandom);
                m1_wren  = $urandom_range(0, 1) == 1;
            end
            m1_lock = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        idle_all();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
